// File: rtl/matmul_sequencer.sv
// Control FSM for one N x N systolic matrix multiply: clear, skewed feed, capture, drain.
// Optional build macro MATMUL_SEQ_PERF_EN adds a saturating downstream-stall counter.
module matmul_sequencer #(
  parameter int N     = 4,
  parameter int CNT_W = 16,
  parameter int ROW_W = $clog2(N)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] k_len_i,
  output logic             busy_o,
  output logic             err_o,
  output logic             clr_pe_o,
  output logic [N-1:0]     feed_en_o,
  output logic             acc_valid_o,
  output logic [ROW_W-1:0] acc_row_sel_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ROW_W-1:0] out_row_o,
  output logic             done_o
`ifdef MATMUL_SEQ_PERF_EN
  ,
  output logic [15:0]      stall_cnt_o
`endif
);

  typedef enum logic [2:0] {IDLE, CLEAR, COMPUTE, CAPTURE, DRAIN} state_e;

  // One extra counter bit so K + 2N - 3 never wraps for the largest K.
  localparam int CW = CNT_W + 1;
  localparam logic [CW-1:0]    CNT_ROW_LAST = CW'(N - 1);
  localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(N - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]   kLen_q, kLen_d;
  logic [CW-1:0]      lastCompute;
  logic               startAccept;

  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               clr_q, clr_d;
  logic [N-1:0]       feed_q, feed_d;
  logic               accValid_q, accValid_d;
  logic [ROW_W-1:0]   accRow_q, accRow_d;
  logic               outValid_q, outValid_d;
  logic [ROW_W-1:0]   outRow_q, outRow_d;
  logic               done_q, done_d;

  assign lastCompute = CW'(kLen_q) + CW'(2 * N - 3);
  assign startAccept = (state_q == IDLE) && start_i && (k_len_i != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kLen_d  = kLen_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (startAccept) begin
          kLen_d  = k_len_i;
          cnt_d   = '0;
          state_d = CLEAR;
        end else if (start_i) begin
          err_d = 1'b1;
        end
      end
      CLEAR: begin
        cnt_d   = '0;
        state_d = COMPUTE;
      end
      COMPUTE: begin
        if (cnt_q == lastCompute) begin
          cnt_d   = '0;
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CAPTURE: begin
        if (cnt_q == CNT_ROW_LAST) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        if (out_ready_i) begin
          if (cnt_q == CNT_ROW_LAST) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they appear registered in step with it.
    busy_d     = (state_d != IDLE);
    clr_d      = (state_d == CLEAR);
    accValid_d = (state_d == CAPTURE);
    accRow_d   = (state_d == CAPTURE) ? (ROW_LAST - cnt_d[ROW_W-1:0]) : '0;
    outValid_d = (state_d == DRAIN);
    outRow_d   = (state_d == DRAIN) ? cnt_d[ROW_W-1:0] : '0;
    feed_d     = '0;
    for (int r = 0; r < N; r++) begin
      feed_d[r] = (state_d == COMPUTE) && (cnt_d >= CW'(r)) &&
                  ((cnt_d - CW'(r)) < {1'b0, kLen_d});
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      kLen_q     <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      clr_q      <= 1'b0;
      feed_q     <= '0;
      accValid_q <= 1'b0;
      accRow_q   <= '0;
      outValid_q <= 1'b0;
      outRow_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      kLen_q     <= kLen_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      clr_q      <= clr_d;
      feed_q     <= feed_d;
      accValid_q <= accValid_d;
      accRow_q   <= accRow_d;
      outValid_q <= outValid_d;
      outRow_q   <= outRow_d;
      done_q     <= done_d;
    end
  end

  assign busy_o        = busy_q;
  assign err_o         = err_q;
  assign clr_pe_o      = clr_q;
  assign feed_en_o     = feed_q;
  assign acc_valid_o   = accValid_q;
  assign acc_row_sel_o = accRow_q;
  assign out_valid_o   = outValid_q;
  assign out_row_o     = outRow_q;
  assign done_o        = done_q;

`ifdef MATMUL_SEQ_PERF_EN
  logic [15:0] stall_q, stall_d;

  // Counts drain cycles where a row is offered but not taken; saturates rather than wraps.
  always_comb begin
    stall_d = stall_q;
    if (startAccept) begin
      stall_d = '0;
    end else if ((state_q == DRAIN) && !out_ready_i && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer: job timing is predicted from cycle offsets since start accept.
// Also checks stall_cnt_o when built with MATMUL_SEQ_PERF_EN.
module tb_matmul_sequencer;

  localparam int N     = 4;
  localparam int CNT_W = 16;
  localparam int ROW_W = $clog2(N);
  localparam int VW    = 6 + N + 2 * ROW_W;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic [CNT_W-1:0] k_len_i;
  logic             busy_o, err_o, clr_pe_o;
  logic [N-1:0]     feed_en_o;
  logic             acc_valid_o;
  logic [ROW_W-1:0] acc_row_sel_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [ROW_W-1:0] out_row_o;
  logic             done_o;
`ifdef MATMUL_SEQ_PERF_EN
  logic [15:0]      stall_cnt_o;
`endif

  int checks   = 0;
  int failures = 0;

  matmul_sequencer #(.N(N), .CNT_W(CNT_W)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .k_len_i       (k_len_i),
    .busy_o        (busy_o),
    .err_o         (err_o),
    .clr_pe_o      (clr_pe_o),
    .feed_en_o     (feed_en_o),
    .acc_valid_o   (acc_valid_o),
    .acc_row_sel_o (acc_row_sel_o),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_row_o     (out_row_o),
    .done_o        (done_o)
`ifdef MATMUL_SEQ_PERF_EN
    ,
    .stall_cnt_o   (stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Expected outputs d cycles after the start was accepted, with 'beats' rows already handed off.
  function automatic logic [VW-1:0] expVec(int d, int k, int beats, bit isDone);
    logic busy = 0, clr = 0, accValid = 0, outValid = 0, done = 0;
    logic [N-1:0]     feed = '0;
    logic [ROW_W-1:0] accRow = '0, outRow = '0;
    int c;
    if (isDone) begin
      done = 1;
    end else if (d == 1) begin
      busy = 1; clr = 1;
    end else if (d <= k + 2 * N - 1) begin
      busy = 1;
      c = d - 2;
      for (int r = 0; r < N; r++) feed[r] = (c >= r) && (c <= r + k - 1);
    end else if (d <= k + 3 * N - 1) begin
      busy = 1; accValid = 1;
      accRow = ROW_W'(N - 1 - (d - (k + 2 * N)));
    end else begin
      busy = 1; outValid = 1;
      outRow = ROW_W'(beats);
    end
    return {busy, 1'b0, clr, feed, accValid, accRow, outValid, outRow, done};
  endfunction

  function automatic logic [VW-1:0] obsVec();
    return {busy_o, err_o, clr_pe_o, feed_en_o, acc_valid_o, acc_row_sel_o,
            out_valid_o, out_row_o, done_o};
  endfunction

  task automatic test_reset();
    logic [VW-1:0] obs;
    rst_i = 1; start_i = 0; k_len_i = '0; out_ready_i = 0;
    repeat (2) tick();
    obs = obsVec();
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%b want=%b", obs, {VW{1'b0}});
    end
`ifdef MATMUL_SEQ_PERF_EN
    checks++;
    if (stall_cnt_o !== 16'd0) begin
      failures++;
      $display("[TB] FAIL reset_stall got=%0d want=0", stall_cnt_o);
    end
`endif
    @(negedge clk_i);
    rst_i = 0;
    tick();
    obs = obsVec();
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("[TB] FAIL idle_after_reset got=%b want=%b", obs, {VW{1'b0}});
    end
  endtask

  // readyMode: 0 always ready, 1 ready low then high alternately in drain, 2 random.
  task automatic test_jobs(string name, int k, int readyMode, bit noiseStart);
    logic [VW-1:0] exp, obs;
    int beats = 0, stalls = 0, drainCyc = 0;
    bit finished = 0, inDrain, rdy;
    start_i = 1; k_len_i = CNT_W'(k); out_ready_i = 0;
    tick();
    start_i = 0;
    for (int d = 1; d <= k + 3 * N + 400; d++) begin
      exp = expVec(d, k, beats, finished);
      obs = obsVec();
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("[TB] FAIL %s d=%0d got=%b want=%b", name, d, obs, exp);
      end
      if (finished) break;
      inDrain = (d >= k + 3 * N);
      case (readyMode)
        0:       rdy = 1'b1;
        1:       rdy = (drainCyc % 2) == 1;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready_i = rdy;
      if (noiseStart) begin
        start_i = 1'($urandom_range(0, 1));
        k_len_i = CNT_W'($urandom_range(0, 5));
      end
      tick();
      if (inDrain) begin
        drainCyc++;
        if (rdy) beats++;
        else stalls++;
        if (beats == N) finished = 1;
      end
    end
    start_i = 0; out_ready_i = 0;
    if (!finished) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout beats=%0d want=%0d", name, beats, N);
    end
`ifdef MATMUL_SEQ_PERF_EN
    checks++;
    if (stall_cnt_o !== 16'(stalls)) begin
      failures++;
      $display("[TB] FAIL %s_stall_cnt got=%0d want=%0d", name, stall_cnt_o, stalls);
    end
`endif
    tick();
    obs = obsVec();
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("[TB] FAIL %s_idle got=%b want=%b", name, obs, {VW{1'b0}});
    end
  endtask

  task automatic test_err();
    logic [VW-1:0] exp, obs;
    exp = '0;
    exp[VW-2] = 1'b1;
    start_i = 1; k_len_i = '0;
    tick();
    start_i = 0;
    obs = obsVec();
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL err_pulse got=%b want=%b", obs, exp);
    end
    tick();
    obs = obsVec();
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("[TB] FAIL err_clears got=%b want=%b", obs, {VW{1'b0}});
    end
  endtask

  task automatic test_reset_mid();
    logic [VW-1:0] exp, obs;
    int k = 3;
    int d = k + 2 * N + 1;
    start_i = 1; k_len_i = CNT_W'(k); out_ready_i = 1;
    tick();
    start_i = 0;
    repeat (d - 1) tick();
    exp = expVec(d, k, 0, 0);
    obs = obsVec();
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL mid_capture got=%b want=%b", obs, exp);
    end
    #3 rst_i = 1;
    #1;
    obs = obsVec();
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("[TB] FAIL async_reset got=%b want=%b", obs, {VW{1'b0}});
    end
    @(negedge clk_i);
    rst_i = 0;
    out_ready_i = 0;
    repeat (3) tick();
    obs = obsVec();
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("[TB] FAIL abandoned_job got=%b want=%b", obs, {VW{1'b0}});
    end
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] exp, obs;
    int k = 1, job = 0, d = 1, beats;
    bit isDone;
    start_i = 1; k_len_i = CNT_W'(k); out_ready_i = 1;
    tick();
    for (int cyc = 0; cyc < 200 && job < 2; cyc++) begin
      isDone = (d == k + 4 * N);
      beats  = (d > k + 3 * N) ? d - (k + 3 * N) : 0;
      exp = expVec(d, k, beats, isDone);
      obs = obsVec();
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("[TB] FAIL back_to_back job=%0d d=%0d got=%b want=%b", job, d, obs, exp);
      end
      if (isDone) begin
        job++;
        d = 0;
        if (job == 2) start_i = 0;
      end
      tick();
      d++;
    end
    if (job < 2) begin
      checks++;
      failures++;
      $display("[TB] FAIL back_to_back_timeout jobs=%0d want=2", job);
    end
    obs = obsVec();
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("[TB] FAIL back_to_back_idle got=%b want=%b", obs, {VW{1'b0}});
    end
    start_i = 0; out_ready_i = 0;
  endtask

  initial begin
    test_reset();
    test_jobs("basic_k3", 3, 0, 0);
    test_jobs("stall_k3", 3, 1, 1);
    test_err();
    test_reset_mid();
    test_jobs("after_reset_k1", 1, 0, 0);
    test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      test_jobs($sformatf("random_%0d", i), int'($urandom_range(1, 9)), 2, 1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
